// File: rtl/nn_pe_seq_if.sv
// Port bundle between the nn_pe_seq sequencer (master) and its environment:
// weight load port, input sample stream, PE drive/return and result stream.
interface nn_pe_seq_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 2
);
   localparam int AW = $clog2(N_IN * N_OUT);
   localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   // Handshakes: a beat transfers on a rising clk edge where valid & ready are
   // both high; the source holds data stable while valid is high and not ready.
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [15:0]   w_data;
   logic [15:0]   x_in;
   logic          x_valid;
   logic          x_ready;
   logic          pe_clr;
   logic [15:0]   pe_x;
   logic [15:0]   pe_w;
   logic [15:0]   pe_z;
   logic [15:0]   y;
   logic [JW-1:0] y_idx;
   logic          y_valid;
   logic          y_ready;
   logic          busy;
   logic          done;
   logic [2:0]    state_dbg;

   modport master (
      input  w_we, w_addr, w_data, x_in, x_valid, pe_z, y_ready,
      output x_ready, pe_clr, pe_x, pe_w, y, y_idx, y_valid, busy, done, state_dbg
   );

   modport slave (
      output w_we, w_addr, w_data, x_in, x_valid, pe_z, y_ready,
      input  x_ready, pe_clr, pe_x, pe_w, y, y_idx, y_valid, busy, done, state_dbg
   );
endinterface

// File: rtl/nn_pe_seq.sv
// Fully connected layer sequencer: buffers one input vector, replays (x, w)
// pairs into an external MAC element per neuron and streams activated results.
module nn_pe_seq #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 2,
   parameter int ACT   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   nn_pe_seq_if.master  bus
);
   localparam int NW = N_IN * N_OUT;
   localparam int AW = $clog2(NW);
   localparam int IW = $clog2(N_IN);
   localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   typedef enum logic [2:0] {
      S_LOAD = 3'd0,
      S_CLR  = 3'd1,
      S_MAC  = 3'd2,
      S_CAP  = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] i;
   logic [JW-1:0] j;
   logic [15:0]   xbuf [N_IN];
   logic [15:0]   wmem [NW];
   logic [15:0]   y_q;
   logic [JW-1:0] y_idx_q;
   logic          done_q;

   logic          i_last;
   logic          j_last;
   logic          w_ok;
   logic [AW-1:0] widx;
   logic [15:0]   act_z;

   assign i_last = (i == IW'(N_IN - 1));
   assign j_last = (j == JW'(N_OUT - 1));
   assign w_ok   = ({1'b0, bus.w_addr} < (AW + 1)'(NW));
   assign widx   = AW'(j) * AW'(N_IN) + AW'(i);
   // ReLU only inspects the sign bit; PE wraparound passes through untouched.
   assign act_z  = ((ACT != 0) && bus.pe_z[15]) ? 16'h0000 : bus.pe_z;

   always_comb begin
      state_nx = state;
      unique case (state)
         S_LOAD:  if (bus.x_valid && i_last) state_nx = S_CLR;
         S_CLR:   state_nx = S_MAC;
         S_MAC:   if (i_last) state_nx = S_CAP;
         S_CAP:   state_nx = S_OUT;
         S_OUT:   if (bus.y_ready) state_nx = j_last ? S_LOAD : S_CLR;
         default: state_nx = S_LOAD;
      endcase
   end

   // Every output is decoded from registered state only.
   always_comb begin
      bus.x_ready = (state == S_LOAD);
      bus.busy    = (state != S_LOAD);
      bus.y_valid = (state == S_OUT);
      bus.pe_clr  = (state == S_CLR);
      bus.pe_x    = 16'h0000;
      bus.pe_w    = 16'h0000;
      if (state == S_MAC) begin
         bus.pe_x = xbuf[i];
         bus.pe_w = wmem[widx];
      end
   end

   assign bus.y         = y_q;
   assign bus.y_idx     = y_idx_q;
   assign bus.done      = done_q;
   assign bus.state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_LOAD;
         i       <= '0;
         j       <= '0;
         y_q     <= '0;
         y_idx_q <= '0;
         done_q  <= 1'b0;
         for (int k = 0; k < N_IN; k++) xbuf[k] <= '0;
         for (int k = 0; k < NW; k++)   wmem[k] <= '0;
      end else begin
         state  <= state_nx;
         done_q <= 1'b0;
         unique case (state)
            S_LOAD: begin
               if (bus.w_we && w_ok) wmem[bus.w_addr] <= bus.w_data;
               if (bus.x_valid) begin
                  xbuf[i] <= bus.x_in;
                  if (i_last) begin
                     i <= '0;
                     j <= '0;
                  end else begin
                     i <= i + 1'b1;
                  end
               end
            end
            S_MAC: i <= i_last ? '0 : i + 1'b1;
            S_CAP: begin
               y_q     <= act_z;
               y_idx_q <= j;
            end
            S_OUT: begin
               if (bus.y_ready) begin
                  if (j_last) done_q <= 1'b1;
                  else        j      <= j + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_nn_pe_seq.sv
// Bench for nn_pe_seq: linear and ReLU instances in lockstep, each driving a
// behavioural MAC element; results checked against tables and a sum model.
module tb_nn_pe_seq;
   localparam int N_IN  = 4;
   localparam int N_OUT = 2;
   localparam int NW    = N_IN * N_OUT;
   localparam int AW    = $clog2(NW);
   localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int QW    = JW + 32;

   typedef struct packed {
      logic [N_IN-1:0][15:0]  x;
      logic [NW-1:0][15:0]    w;
      logic [N_OUT-1:0][15:0] yl;
      logic [N_OUT-1:0][15:0] yr;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   nn_pe_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus_l ();
   nn_pe_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus_r ();

   nn_pe_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .ACT(0)) dut_lin (.clk(clk), .rst_n(rst_n), .bus(bus_l));
   nn_pe_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .ACT(1)) dut_relu (.clk(clk), .rst_n(rst_n), .bus(bus_r));

   assign bus_r.w_we    = bus_l.w_we;
   assign bus_r.w_addr  = bus_l.w_addr;
   assign bus_r.w_data  = bus_l.w_data;
   assign bus_r.x_in    = bus_l.x_in;
   assign bus_r.x_valid = bus_l.x_valid;
   assign bus_r.y_ready = bus_l.y_ready;

   function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
   endfunction

   // MAC element: clear or accumulate on every edge, z = acc[25:10].
   logic [31:0] acc_l;
   logic [31:0] acc_r;
   always_ff @(posedge clk) begin
      if (!rst_n || bus_l.pe_clr) acc_l <= '0;
      else acc_l <= acc_l + mul16(bus_l.pe_x, bus_l.pe_w);
      if (!rst_n || bus_r.pe_clr) acc_r <= '0;
      else acc_r <= acc_r + mul16(bus_r.pe_x, bus_r.pe_w);
   end
   assign bus_l.pe_z = acc_l[25:10];
   assign bus_r.pe_z = acc_r[25:10];

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference: weights known to the bench, exact integer dot product.
   logic [15:0] w_sh [NW];

   function automatic logic [15:0] ref_neuron(input logic [N_IN-1:0][15:0] xv, input int n, input bit relu);
      longint s;
      logic [63:0] u;
      logic [15:0] r;
      s = 0;
      for (int k = 0; k < N_IN; k++)
         s += longint'($signed(xv[k])) * longint'($signed(w_sh[n * N_IN + k]));
      u = s;
      r = u[25:10];
      if (relu && r[15]) r = 16'h0000;
      return r;
   endfunction

   // Scoreboard and protocol monitor, sampled on the falling edge.
   logic [QW-1:0] exp_q[$];
   logic [QW-1:0] e;
   logic          hold_prev = 1'b0;
   logic          yv_prev = 1'b0;
   logic          expect_done = 1'b0;
   logic [15:0]   y_prev = '0;
   logic [JW-1:0] idx_prev = '0;
   int            last_evt = 0;
   int            clr_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev   = 1'b0;
         yv_prev     = 1'b0;
         expect_done = 1'b0;
      end else begin
         check_eq("ready_vs_busy", 32'(bus_l.x_ready), 32'(!bus_l.busy));
         check_eq("lockstep_valid", 32'(bus_r.y_valid), 32'(bus_l.y_valid));
         check_eq("done_pulse", 32'(bus_l.done), 32'(expect_done));
         if (bus_l.pe_clr) clr_cnt++;
         if (!bus_l.busy || bus_l.pe_clr || bus_l.y_valid)
            check_eq("pe_operands_idle", {bus_l.pe_x, bus_l.pe_w}, 32'h0);
         if (!bus_l.busy || bus_l.y_valid)
            check_eq("pe_clr_idle", 32'(bus_l.pe_clr), 32'h0);
         if (hold_prev) begin
            check_eq("hold_valid", 32'(bus_l.y_valid), 32'h1);
            check_eq("hold_y", 32'(bus_l.y), 32'(y_prev));
            check_eq("hold_idx", 32'(bus_l.y_idx), 32'(idx_prev));
         end
         // The triggering accept/handshake edge counts as the first edge.
         if (bus_l.y_valid && !yv_prev)
            check_eq("latency", 32'(cyc - last_evt + 1), 32'(N_IN + 3));
         if (bus_l.y_valid && bus_l.y_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got y=%h idx=%h expected none", bus_l.y, bus_l.y_idx);
            end else begin
               e = exp_q.pop_front();
               check_eq("y_linear", 32'(bus_l.y), 32'(e[15:0]));
               check_eq("y_relu", 32'(bus_r.y), 32'(e[31:16]));
               check_eq("y_idx", 32'(bus_l.y_idx), 32'(e[QW-1:32]));
               check_eq("y_idx_relu", 32'(bus_r.y_idx), 32'(e[QW-1:32]));
            end
            last_evt = cyc + 1;
         end
         if (bus_l.x_valid && bus_l.x_ready) last_evt = cyc + 1;
         expect_done = bus_l.y_valid && bus_l.y_ready && (bus_l.y_idx == JW'(N_OUT - 1));
         hold_prev   = bus_l.y_valid && !bus_l.y_ready;
         y_prev      = bus_l.y;
         idx_prev    = bus_l.y_idx;
         yv_prev     = bus_l.y_valid;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_x_ready"}, 32'(bus_l.x_ready), 32'h1);
      check_eq({tag, "_busy"}, 32'(bus_l.busy), 32'h0);
      check_eq({tag, "_y_valid"}, 32'(bus_l.y_valid), 32'h0);
      check_eq({tag, "_y"}, 32'(bus_l.y), 32'h0);
      check_eq({tag, "_y_relu"}, 32'(bus_r.y), 32'h0);
      check_eq({tag, "_y_idx"}, 32'(bus_l.y_idx), 32'h0);
      check_eq({tag, "_pe_clr"}, 32'(bus_l.pe_clr), 32'h0);
      check_eq({tag, "_pe_xw"}, {bus_l.pe_x, bus_l.pe_w}, 32'h0);
      check_eq({tag, "_done"}, 32'(bus_l.done), 32'h0);
   endtask

   task automatic load_weights(input logic [NW-1:0][15:0] w);
      for (int a = 0; a < NW; a++) begin
         bus_l.w_we   = 1'b1;
         bus_l.w_addr = AW'(a);
         bus_l.w_data = w[a];
         w_sh[a]      = w[a];
         @(posedge clk); #1;
      end
      bus_l.w_we = 1'b0;
   endtask

   task automatic stream(input logic [N_IN-1:0][15:0] xv, input bit gaps);
      for (int k = 0; k < N_IN; k++) begin
         bus_l.x_valid = 1'b0;
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         bus_l.x_valid = 1'b1;
         bus_l.x_in    = xv[k];
         @(posedge clk); #1;
      end
      bus_l.x_valid = 1'b0;
   endtask

   // mode 0: always ready; 1: random gaps/ready; 2: 5-cycle backpressure;
   // 3: weight write and sample offered while the MAC phase runs.
   task automatic run_vector(input logic [N_IN-1:0][15:0] xv, input logic [N_OUT-1:0][15:0] yl,
                             input logic [N_OUT-1:0][15:0] yr, input int mode);
      int n_cyc;
      int held;
      bit fin;
      for (int n = 0; n < N_OUT; n++) exp_q.push_back({JW'(n), yr[n], yl[n]});
      clr_cnt = 0;
      bus_l.y_ready = (mode == 2) ? 1'b0 : 1'b1;
      stream(xv, mode == 1);
      n_cyc = 0;
      held  = 0;
      fin   = 1'b0;
      while (!fin && n_cyc < 300) begin
         @(posedge clk); #1;
         n_cyc++;
         if (bus_l.done) fin = 1'b1;
         case (mode)
            1: bus_l.y_ready = 1'($urandom_range(0, 1));
            2: if (bus_l.y_valid && !bus_l.y_ready) begin
                  check_eq("bp_busy", 32'(bus_l.busy), 32'h1);
                  check_eq("bp_x_ready", 32'(bus_l.x_ready), 32'h0);
                  check_eq("bp_pe_clr", 32'(bus_l.pe_clr), 32'h0);
                  held++;
                  if (held == 6) bus_l.y_ready = 1'b1;
               end
            3: if (n_cyc == 2) begin
                  bus_l.w_we    = 1'b1;
                  bus_l.w_addr  = '0;
                  bus_l.w_data  = 16'h7FFF;
                  bus_l.x_valid = 1'b1;
                  bus_l.x_in    = 16'h7777;
               end else if (n_cyc == 3) begin
                  check_eq("mac_x_ready", 32'(bus_l.x_ready), 32'h0);
                  bus_l.w_we    = 1'b0;
                  bus_l.x_valid = 1'b0;
               end
            default: ;
         endcase
      end
      if (!fin) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done within 300 cycles, expected one");
      end
      bus_l.y_ready = 1'b1;
      check_eq("clr_per_vector", 32'(clr_cnt), 32'(N_OUT));
      check_eq("results_drained", 32'(exp_q.size()), 32'h0);
   endtask

   vec_t tbl [4];

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: got no end of test, expected one before time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [N_IN-1:0][15:0]  xr;
      logic [NW-1:0][15:0]    wr;
      logic [N_OUT-1:0][15:0] el;
      logic [N_OUT-1:0][15:0] er;
      bit do_load;

      tbl[0].x  = {16'h1000, 16'h0C00, 16'h0800, 16'h0400};
      tbl[0].w  = {{4{16'hFC00}}, {4{16'h0400}}};
      tbl[0].yl = {16'hD800, 16'h2800};
      tbl[0].yr = {16'h0000, 16'h2800};
      tbl[1].x  = {4{16'h0400}};
      tbl[1].w  = {{4{16'hFC00}}, {4{16'h0400}}};
      tbl[1].yl = {16'hF000, 16'h1000};
      tbl[1].yr = {16'h0000, 16'h1000};
      tbl[2].x  = {4{16'h7FFF}};
      tbl[2].w  = {{4{16'h8000}}, {4{16'h7FFF}}};
      tbl[2].yl = {16'h0080, 16'hFF00};
      tbl[2].yr = {16'h0080, 16'h0000};
      tbl[3].x  = {16'hFFFF, 16'h0200, 16'hFC00, 16'h0400};
      tbl[3].w  = {{4{16'h0100}}, 16'h0400, 16'hF800, 16'h0400, 16'h0800};
      tbl[3].yl = {16'h007F, 16'hFFFF};
      tbl[3].yr = {16'h007F, 16'h0000};

      bus_l.w_we    = 1'b0;
      bus_l.w_addr  = '0;
      bus_l.w_data  = '0;
      bus_l.x_in    = '0;
      bus_l.x_valid = 1'b0;
      bus_l.y_ready = 1'b1;
      for (int a = 0; a < NW; a++) w_sh[a] = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int t = 0; t < 4; t++) begin
         do_load = (t == 0);
         if (t > 0) do_load = (tbl[t].w != tbl[t-1].w);
         if (do_load) load_weights(tbl[t].w);
         run_vector(tbl[t].x, tbl[t].yl, tbl[t].yr, 0);
      end

      load_weights(tbl[0].w);
      run_vector(tbl[0].x, tbl[0].yl, tbl[0].yr, 2);
      run_vector(tbl[0].x, tbl[0].yl, tbl[0].yr, 3);
      run_vector(tbl[0].x, tbl[0].yl, tbl[0].yr, 0);

      for (int v = 0; v < 24; v++) begin
         if (v == 0 || $urandom_range(0, 1) == 1) begin
            for (int a = 0; a < NW; a++) wr[a] = 16'($urandom);
            load_weights(wr);
         end
         for (int k = 0; k < N_IN; k++) xr[k] = 16'($urandom);
         for (int n = 0; n < N_OUT; n++) begin
            el[n] = ref_neuron(xr, n, 1'b0);
            er[n] = ref_neuron(xr, n, 1'b1);
         end
         run_vector(xr, el, er, 1);
      end

      load_weights(tbl[0].w);
      stream(tbl[0].x, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("mid_mac_reset");
      rst_n = 1'b1;
      for (int a = 0; a < NW; a++) w_sh[a] = '0;
      run_vector(tbl[0].x, {16'h0000, 16'h0000}, {16'h0000, 16'h0000}, 0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
